// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm sequencer for the digital clock.
// Holds the BCD alarm time, lets the user edit it with buttons, arms/disarms,
// detects a match against the running time, and runs the ringing phase with a
// timeout and a bounded snooze.
//
// Optional build macro: ALARM_BLINK_EN -- when defined, led_alarm blinks
// (1111/0000, toggling on each tick_1hz) while ringing; otherwise steady 1111.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   tick_1hz           one-cycle pulse per second
//   hr, mn             current time, BCD
//   btn_set/inc/arm/snooze  debounced one-cycle button pulses
//   hr_alarm, mn_alarm alarm time, BCD
//   edit_sel           00 none, 01 hour, 10 minute
//   armed, ringing     status flags
//   led_alarm          alarm LED pattern
//
// state    | meaning
// DISARMED | alarm off
// SET_HR   | editing alarm hour
// SET_MN   | editing alarm minute
// ARMED    | waiting for the alarm time
// RINGING  | alarm sounding, ring timer running
// SNOOZE   | waiting for the snooze target time
module alarm_ctrl #(
  parameter logic [7:0] RST_HR     = 8'h07,
  parameter logic [7:0] RST_MN     = 8'h00,
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MN  = 5,
  parameter int         MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [7:0] hr,
  input  logic [7:0] mn,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_arm,
  input  logic       btn_snooze,
  output logic [7:0] hr_alarm,
  output logic [7:0] mn_alarm,
  output logic [1:0] edit_sel,
  output logic       armed,
  output logic       ringing,
  output logic [3:0] led_alarm
);

  typedef enum logic [2:0] {DISARMED, SET_HR, SET_MN, ARMED, RINGING, SNOOZE} state_t;

  state_t     state, state_nxt;
  logic [7:0] hr_nxt, mn_nxt;
  logic [7:0] ring_cnt, ring_nxt;
  logic [3:0] snooze_cnt, snooze_nxt;
  logic [7:0] tgt_hr, tgt_hr_nxt, tgt_mn, tgt_mn_nxt;
  logic       fired, fired_nxt;
  logic       time_eq, tgt_eq;
  logic [6:0] snz_h, snz_m;
  logic [1:0] edit_sel_d;
  logic       armed_d, ringing_d;
  logic [3:0] led_d;

  // BCD increment with wrap at max (23 for hours, 59 for minutes)
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return (8'(v / 7'd10) << 4) | 8'(v % 7'd10);
  endfunction

  assign time_eq = (hr == hr_alarm) && (mn == mn_alarm);
  assign tgt_eq  = (hr == tgt_hr) && (mn == tgt_mn);

  // Snooze target = now + SNOOZE_MN minutes, wrapping past midnight
  always_comb begin
    snz_m = bcd2bin(mn) + 7'(SNOOZE_MN);
    snz_h = bcd2bin(hr);
    if (snz_m >= 7'd60) begin
      snz_m = snz_m - 7'd60;
      snz_h = snz_h + 7'd1;
    end
    if (snz_h == 7'd24) snz_h = 7'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DISARMED;
      hr_alarm   <= RST_HR;
      mn_alarm   <= RST_MN;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 4'd0;
      tgt_hr     <= 8'h00;
      tgt_mn     <= 8'h00;
      fired      <= 1'b0;
      edit_sel   <= 2'b00;
      armed      <= 1'b0;
      ringing    <= 1'b0;
      led_alarm  <= 4'b0000;
    end else begin
      state      <= state_nxt;
      hr_alarm   <= hr_nxt;
      mn_alarm   <= mn_nxt;
      ring_cnt   <= ring_nxt;
      snooze_cnt <= snooze_nxt;
      tgt_hr     <= tgt_hr_nxt;
      tgt_mn     <= tgt_mn_nxt;
      fired      <= fired_nxt;
      edit_sel   <= edit_sel_d;
      armed      <= armed_d;
      ringing    <= ringing_d;
      led_alarm  <= led_d;
    end
  end

  // Buttons take priority over time matches in ARMED and SNOOZE.
  always_comb begin
    state_nxt  = state;
    hr_nxt     = hr_alarm;
    mn_nxt     = mn_alarm;
    ring_nxt   = ring_cnt;
    snooze_nxt = snooze_cnt;
    tgt_hr_nxt = tgt_hr;
    tgt_mn_nxt = tgt_mn;
    fired_nxt  = time_eq ? fired : 1'b0;
    case (state)
      DISARMED: begin
        if (btn_arm)      state_nxt = ARMED;
        else if (btn_set) state_nxt = SET_HR;
      end
      SET_HR: begin
        if (btn_arm)      state_nxt = DISARMED;
        else if (btn_set) state_nxt = SET_MN;
        else if (btn_inc) begin
          hr_nxt    = bcd_inc(hr_alarm, 8'h23);
          fired_nxt = 1'b0;
        end
      end
      SET_MN: begin
        if (btn_arm)      state_nxt = DISARMED;
        else if (btn_set) state_nxt = ARMED;
        else if (btn_inc) begin
          mn_nxt    = bcd_inc(mn_alarm, 8'h59);
          fired_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (btn_arm)      state_nxt = DISARMED;
        else if (btn_set) state_nxt = SET_HR;
        else if (time_eq && !fired) begin
          state_nxt  = RINGING;
          fired_nxt  = 1'b1;
          ring_nxt   = 8'd0;
          snooze_nxt = 4'd0;
        end
      end
      RINGING: begin
        if (btn_arm) state_nxt = ARMED;
        else if (btn_snooze) begin
          if (snooze_cnt < 4'(MAX_SNOOZE)) begin
            state_nxt  = SNOOZE;
            snooze_nxt = snooze_cnt + 4'd1;
            tgt_hr_nxt = bin2bcd(snz_h);
            tgt_mn_nxt = bin2bcd(snz_m);
          end else begin
            state_nxt = ARMED;
          end
        end else if (tick_1hz) begin
          ring_nxt = ring_cnt + 8'd1;
          if (ring_cnt + 8'd1 == 8'(RING_SEC)) state_nxt = ARMED;
        end
      end
      SNOOZE: begin
        if (btn_arm) state_nxt = ARMED;
        else if (tgt_eq) begin
          state_nxt = RINGING;
          ring_nxt  = 8'd0;
        end
      end
      default: state_nxt = DISARMED;
    endcase
  end

  // Outputs are decoded from the next state and registered above.
  always_comb begin
    edit_sel_d = 2'b00;
    armed_d    = 1'b0;
    ringing_d  = 1'b0;
    led_d      = 4'b0000;
    case (state_nxt)
      SET_HR: edit_sel_d = 2'b01;
      SET_MN: edit_sel_d = 2'b10;
      ARMED:  armed_d = 1'b1;
      RINGING: begin
        armed_d   = 1'b1;
        ringing_d = 1'b1;
`ifdef ALARM_BLINK_EN
        if (state != RINGING) led_d = 4'b1111;
        else if (tick_1hz)    led_d = ~led_alarm;
        else                  led_d = led_alarm;
`else
        led_d = 4'b1111;
`endif
      end
      SNOOZE: begin
        armed_d = 1'b1;
        led_d   = 4'b0001;
      end
      default: ;
    endcase
  end

endmodule
